// File: rtl/ascon_ctrl_fsm_if.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_fsm_if
// Handshake and datapath-control bundle between the ASCON-128 control FSM,
// the host that supplies 64-bit blocks, and the permutation/XOR datapath.
//
//   start_i         host -> fsm   start pulse (sampled only when idle)
//   data_valid_i    host -> fsm   AD/plaintext block is stable on data64
//   data_ready_o    fsm  -> host  block consumed this cycle
//   round_o         fsm  -> dp    permutation round index 0..11
//   input_select_o  fsm  -> dp    0 = load external state, 1 = loop back
//   xorup_select_o  fsm  -> dp    XOR data64 into x0 before the round
//   xordn_select_o  fsm  -> dp    post-round XOR: 00 none, 01 key, 10 domain bit
//   final_o         fsm  -> dp    XOR key into x1/x2 before the round
//   ena_reg_o       fsm  -> dp    state register write enable
//   ena_cipher_o    fsm  -> dp    capture ciphertext this cycle
//   ena_tag_o       fsm  -> dp    capture tag this cycle
//   busy_o          fsm  -> host  high outside IDLE
//   done_o          fsm  -> host  one-cycle pulse when the tag is valid
//
// The slave modport is the FSM; the master modport is the host/datapath side.
// ---------------------------------------------------------------------------
interface ascon_ctrl_fsm_if;
    logic       start_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic [3:0] round_o;
    logic       input_select_o;
    logic       xorup_select_o;
    logic [1:0] xordn_select_o;
    logic       final_o;
    logic       ena_reg_o;
    logic       ena_cipher_o;
    logic       ena_tag_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        output start_i, data_valid_i,
        input  data_ready_o, round_o, input_select_o, xorup_select_o,
               xordn_select_o, final_o, ena_reg_o, ena_cipher_o, ena_tag_o,
               busy_o, done_o
    );

    modport slave (
        input  start_i, data_valid_i,
        output data_ready_o, round_o, input_select_o, xorup_select_o,
               xordn_select_o, final_o, ena_reg_o, ena_cipher_o, ena_tag_o,
               busy_o, done_o
    );
endinterface

// File: rtl/ascon_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// ascon_ctrl_fsm
// Control sequencer for ASCON-128 encryption. Drives every control input of
// the permutation/XOR datapath through: initialisation (p12), one associated
// data block (p6), NB_PT-1 full plaintext blocks (p6 each) and finalisation
// (p12, which also absorbs the last plaintext block and extracts the tag).
//
// Ports:
//   clock_i  rising-edge clock
//   reset_i  asynchronous active-high reset
//   bus      ascon_ctrl_fsm_if.slave (start/valid in, all controls out)
//
// Parameter:
//   NB_PT    plaintext blocks including the final one, 1..255
//
// All outputs are Moore decodes of the state and round counter.
// ---------------------------------------------------------------------------
module ascon_ctrl_fsm #(
    parameter int unsigned NB_PT = 4
) (
    input  logic            clock_i,
    input  logic            reset_i,
    ascon_ctrl_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        WAIT_AD,
        AD,
        WAIT_PT,
        PT,
        WAIT_FIN,
        FINAL,
        DONE
    } state_t;

    // Number of blocks handled in PT; the last plaintext block rides on FINAL.
    localparam logic [7:0] PT_BLOCKS = 8'(NB_PT - 1);

    localparam logic [3:0] ROUND_P12 = 4'd0;
    localparam logic [3:0] ROUND_P6  = 4'd6;
    localparam logic [3:0] ROUND_END = 4'd11;

    state_t     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [7:0] blk_q,   blk_d;

    // NOTE: asynchronous reset clears every register at once; since all
    // outputs decode these registers, the outputs drop in the same cycle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            round_q <= '0;
            blk_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so each register samples the
            // pre-edge values of the others.
            state_q <= state_d;
            round_q <= round_d;
            blk_q   <= blk_d;
        end
    end

    logic last_round;
    logic first_round;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        round_d = round_q;
        blk_d   = blk_q;

        bus.data_ready_o   = 1'b0;
        bus.round_o        = round_q;
        bus.input_select_o = 1'b0;
        bus.xorup_select_o = 1'b0;
        bus.xordn_select_o = 2'b00;
        bus.final_o        = 1'b0;
        bus.ena_reg_o      = 1'b0;
        bus.ena_cipher_o   = 1'b0;
        bus.ena_tag_o      = 1'b0;
        bus.busy_o         = (state_q != IDLE);
        bus.done_o         = (state_q == DONE);

        last_round  = (round_q == ROUND_END);
        // p6 phases start at round 6, p12 phases at round 0.
        first_round = (state_q == AD || state_q == PT) ? (round_q == ROUND_P6)
                                                       : (round_q == ROUND_P12);

        // The round counter rests at 0 outside the round states and is
        // loaded with the phase start value on entry.
        case (state_q)
            IDLE: begin
                round_d = '0;
                blk_d   = '0;
                if (bus.start_i) begin
                    state_d = INIT;
                    round_d = ROUND_P12;
                end
            end

            INIT: begin
                bus.ena_reg_o      = 1'b1;
                bus.input_select_o = first_round ? 1'b0 : 1'b1;
                if (last_round) begin
                    bus.xordn_select_o = 2'b01;
                    state_d            = WAIT_AD;
                    round_d            = '0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            WAIT_AD: begin
                if (bus.data_valid_i) begin
                    state_d = AD;
                    round_d = ROUND_P6;
                end
            end

            AD: begin
                bus.ena_reg_o      = 1'b1;
                bus.input_select_o = 1'b1;
                bus.xorup_select_o = first_round;
                bus.data_ready_o   = first_round;
                if (last_round) begin
                    bus.xordn_select_o = 2'b10;
                    state_d            = (PT_BLOCKS != 8'd0) ? WAIT_PT : WAIT_FIN;
                    round_d            = '0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            WAIT_PT: begin
                if (bus.data_valid_i) begin
                    state_d = PT;
                    round_d = ROUND_P6;
                end
            end

            PT: begin
                bus.ena_reg_o      = 1'b1;
                bus.input_select_o = 1'b1;
                bus.xorup_select_o = first_round;
                bus.data_ready_o   = first_round;
                bus.ena_cipher_o   = first_round;
                if (last_round) begin
                    blk_d   = blk_q + 8'd1;
                    // Compare the post-increment count: it is the number of
                    // PT blocks finished once this round retires.
                    state_d = ((blk_q + 8'd1) < PT_BLOCKS) ? WAIT_PT : WAIT_FIN;
                    round_d = '0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            WAIT_FIN: begin
                if (bus.data_valid_i) begin
                    state_d = FINAL;
                    round_d = ROUND_P12;
                end
            end

            FINAL: begin
                bus.ena_reg_o      = 1'b1;
                bus.input_select_o = 1'b1;
                bus.xorup_select_o = first_round;
                bus.data_ready_o   = first_round;
                bus.ena_cipher_o   = first_round;
                bus.final_o        = first_round;
                if (last_round) begin
                    bus.xordn_select_o = 2'b01;
                    bus.ena_tag_o      = 1'b1;
                    state_d            = DONE;
                    round_d            = '0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
                round_d = '0;
            end

            default: begin
                state_d = IDLE;
                round_d = '0;
                blk_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_ascon_ctrl_fsm
// Self-checking bench for ascon_ctrl_fsm. Two instances (NB_PT=4, NB_PT=1)
// share the clock. Each cycle the selected instance is compared against a
// reference model that expands an operation into a queue of expected output
// words (wait slots hold while data_valid_i is low). A table of scenarios
// checks done timing and strobe counts; hand sequences cover reset mid-run
// and specific cycle stamps; random start/valid/reset stimulus follows.
// ---------------------------------------------------------------------------
module tb_ascon_ctrl_fsm;

    typedef struct packed {
        logic       done;
        logic       busy;
        logic       ena_tag;
        logic       ena_cipher;
        logic       ena_reg;
        logic       fin;
        logic [1:0] xordn;
        logic       xorup;
        logic       insel;
        logic [3:0] round;
        logic       ready;
    } out_t;

    typedef struct packed {
        logic w;      // slot waits for data_valid_i before advancing
        out_t o;
    } rec_t;

    typedef struct {
        bit sel;      // 0: NB_PT=4 instance, 1: NB_PT=1 instance
        int stall_at;
        int stall_len;
        bit glitch;
        int exp_done;
        int exp_cipher;
        int exp_ready;
        int exp_lowrun;
    } scen_t;

    logic clock_i;
    logic rst4, rst1;

    ascon_ctrl_fsm_if bus4 ();
    ascon_ctrl_fsm_if bus1 ();

    ascon_ctrl_fsm #(.NB_PT(4)) dut4 (.clock_i(clock_i), .reset_i(rst4), .bus(bus4));
    ascon_ctrl_fsm #(.NB_PT(1)) dut1 (.clock_i(clock_i), .reset_i(rst1), .bus(bus1));

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int   checks = 0;
    int   errors = 0;
    bit   sel;
    int   nb;
    int   stamp;
    out_t obs [0:255];
    rec_t exp_q [$];
    rec_t cur;

    int done_cnt, done_stamp, cipher_cnt, ready_cnt;
    int low_run, max_low, insel0_cnt, fin_cnt;
    int xd3_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic out_t dut_out(input bit s);
        out_t o;
        if (!s) begin
            o.done = bus4.done_o;           o.busy = bus4.busy_o;
            o.ena_tag = bus4.ena_tag_o;     o.ena_cipher = bus4.ena_cipher_o;
            o.ena_reg = bus4.ena_reg_o;     o.fin = bus4.final_o;
            o.xordn = bus4.xordn_select_o;  o.xorup = bus4.xorup_select_o;
            o.insel = bus4.input_select_o;  o.round = bus4.round_o;
            o.ready = bus4.data_ready_o;
        end else begin
            o.done = bus1.done_o;           o.busy = bus1.busy_o;
            o.ena_tag = bus1.ena_tag_o;     o.ena_cipher = bus1.ena_cipher_o;
            o.ena_reg = bus1.ena_reg_o;     o.fin = bus1.final_o;
            o.xordn = bus1.xordn_select_o;  o.xorup = bus1.xorup_select_o;
            o.insel = bus1.input_select_o;  o.round = bus1.round_o;
            o.ready = bus1.data_ready_o;
        end
        return o;
    endfunction

    // ---------------- reference model ----------------
    task automatic push_wait();
        rec_t r = '0;
        r.w      = 1'b1;
        r.o.busy = 1'b1;
        exp_q.push_back(r);
    endtask

    // kind: 0 init, 1 AD, 2 PT, 3 final
    task automatic push_phase(input int kind);
        int first = (kind == 1 || kind == 2) ? 6 : 0;
        for (int rr = first; rr <= 11; rr++) begin
            rec_t r = '0;
            r.o.busy    = 1'b1;
            r.o.ena_reg = 1'b1;
            r.o.round   = 4'(rr);
            r.o.insel   = (kind != 0) || (rr != 0);
            if (kind != 0 && rr == first) begin
                r.o.xorup      = 1'b1;
                r.o.ready      = 1'b1;
                r.o.ena_cipher = (kind >= 2);
                r.o.fin        = (kind == 3);
            end
            if (rr == 11) begin
                r.o.xordn   = (kind == 1) ? 2'b10 : (kind == 2) ? 2'b00 : 2'b01;
                r.o.ena_tag = (kind == 3);
            end
            exp_q.push_back(r);
        end
    endtask

    task automatic build_op();
        rec_t r = '0;
        exp_q.delete();
        push_phase(0);
        push_wait();
        push_phase(1);
        for (int b = 1; b < nb; b++) begin
            push_wait();
            push_phase(2);
        end
        push_wait();
        push_phase(3);
        r.o.busy = 1'b1;
        r.o.done = 1'b1;
        exp_q.push_back(r);
    endtask

    task automatic model_step(input logic st, input logic vld);
        if (!cur.o.busy) begin
            if (st) begin
                build_op();
                cur = exp_q.pop_front();
            end
        end else if (cur.w && !vld) begin
            // stalled in a wait slot
        end else if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
        end else begin
            cur = '0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        cur = '0;
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic st, input logic vld);
        bus4.start_i      = sel ? 1'b0 : st;
        bus4.data_valid_i = sel ? 1'b0 : vld;
        bus1.start_i      = sel ? st : 1'b0;
        bus1.data_valid_i = sel ? vld : 1'b0;
    endtask

    task automatic clear_tally();
        done_cnt = 0; done_stamp = -1; cipher_cnt = 0; ready_cnt = 0;
        low_run = 0;  max_low = 0;     insel0_cnt = 0; fin_cnt = 0;
    endtask

    // Called right after a negedge; returns right after the next negedge.
    task automatic step(input logic st, input logic vld);
        out_t act;
        drive(st, vld);
        @(posedge clock_i);
        model_step(st, vld);
        @(negedge clock_i);
        stamp++;
        act = dut_out(sel);
        check($sformatf("trace_c%0d_sel%0d", stamp, sel), 32'(act), 32'(cur.o));
        if (stamp >= 0 && stamp < 256) obs[stamp] = act;
        if (act.done) begin
            done_cnt++;
            done_stamp = stamp;
        end
        if (act.ena_cipher) cipher_cnt++;
        if (act.ready) ready_cnt++;
        if (act.fin) fin_cnt++;
        if (act.ena_reg && !act.insel) insel0_cnt++;
        if (act.xordn == 2'b11) xd3_cnt++;
        if (act.busy && !act.ena_reg && !act.done) begin
            low_run++;
            if (low_run > max_low) max_low = low_run;
        end else begin
            low_run = 0;
        end
    endtask

    task automatic do_reset();
        if (!sel) rst4 = 1'b1; else rst1 = 1'b1;
        #1;
        model_reset();
        check($sformatf("async_reset_sel%0d", sel), 32'(dut_out(sel)), 32'd0);
        @(posedge clock_i);
        @(negedge clock_i);
        if (!sel) rst4 = 1'b0; else rst1 = 1'b0;
    endtask

    task automatic run_scen(input scen_t s, input int idx);
        logic st, vld;
        sel   = s.sel;
        nb    = s.sel ? 1 : 4;
        stamp = 0;
        clear_tally();
        step(1'b1, 1'b1);
        while (stamp < 200 && !(done_cnt > 0 && stamp >= done_stamp + 2)) begin
            st  = s.glitch && (stamp == 15 || stamp == 23);
            vld = !(stamp >= s.stall_at && stamp < s.stall_at + s.stall_len);
            step(st, vld);
        end
        check($sformatf("s%0d_done_cycle", idx), 32'(done_stamp), 32'(s.exp_done));
        check($sformatf("s%0d_done_count", idx), 32'(done_cnt), 32'd1);
        check($sformatf("s%0d_cipher_count", idx), 32'(cipher_cnt), 32'(s.exp_cipher));
        check($sformatf("s%0d_ready_count", idx), 32'(ready_cnt), 32'(s.exp_ready));
        check($sformatf("s%0d_ena_reg_low_run", idx), 32'(max_low), 32'(s.exp_lowrun));
        check($sformatf("s%0d_insel0_count", idx), 32'(insel0_cnt), 32'd1);
        check($sformatf("s%0d_final_count", idx), 32'(fin_cnt), 32'd1);
    endtask

    scen_t tbl [5];

    initial begin
        tbl[0] = '{sel: 1'b0, stall_at: 0,  stall_len: 0, glitch: 1'b0,
                   exp_done: 54, exp_cipher: 4, exp_ready: 5, exp_lowrun: 1};
        tbl[1] = '{sel: 1'b0, stall_at: 27, stall_len: 5, glitch: 1'b0,
                   exp_done: 59, exp_cipher: 4, exp_ready: 5, exp_lowrun: 6};
        tbl[2] = '{sel: 1'b0, stall_at: 0,  stall_len: 0, glitch: 1'b1,
                   exp_done: 54, exp_cipher: 4, exp_ready: 5, exp_lowrun: 1};
        tbl[3] = '{sel: 1'b1, stall_at: 0,  stall_len: 0, glitch: 1'b0,
                   exp_done: 33, exp_cipher: 1, exp_ready: 2, exp_lowrun: 1};
        tbl[4] = '{sel: 1'b1, stall_at: 20, stall_len: 3, glitch: 1'b0,
                   exp_done: 36, exp_cipher: 1, exp_ready: 2, exp_lowrun: 4};

        sel  = 1'b0;
        cur  = '0;
        rst4 = 1'b1;
        rst1 = 1'b1;
        drive(1'b0, 1'b0);
        @(negedge clock_i);
        @(negedge clock_i);
        check("reset_state_nb4", 32'(dut_out(1'b0)), 32'd0);
        check("reset_state_nb1", 32'(dut_out(1'b1)), 32'd0);
        rst4 = 1'b0;
        rst1 = 1'b0;
        @(negedge clock_i);
        check("idle_after_reset_nb4", 32'(dut_out(1'b0)), 32'd0);

        // Table-driven scenarios
        for (int i = 0; i < 5; i++) run_scen(tbl[i], i);

        // Reset during the 3rd round of PT block 1, then a full rerun
        sel   = 1'b0;
        nb    = 4;
        stamp = 0;
        clear_tally();
        step(1'b1, 1'b1);
        while (stamp < 23) step(1'b0, 1'b1);
        check("pt1_round3_index", 32'(obs[23].round), 32'd8);
        do_reset();
        check("busy_after_reset", 32'(bus4.busy_o), 32'd0);
        run_scen(tbl[0], 5);

        // Spot checks on the nominal NB_PT=4 rerun
        check("init_r0_round", 32'(obs[1].round), 32'd0);
        check("init_r0_insel", 32'(obs[1].insel), 32'd0);
        check("init_r1_insel", 32'(obs[2].insel), 32'd1);
        check("xordn_c12", 32'(obs[12].xordn), 32'd1);
        check("wait_ad_c13_ena", 32'(obs[13].ena_reg), 32'd0);
        check("ad_first_round", 32'(obs[14].round), 32'd6);
        check("xordn_c19", 32'(obs[19].xordn), 32'd2);
        check("cipher_c21", 32'(obs[21].ena_cipher), 32'd1);
        check("cipher_c42", 32'(obs[42].ena_cipher), 32'd1);
        check("final_c42", 32'(obs[42].fin), 32'd1);
        check("final_round_c42", 32'(obs[42].round), 32'd0);
        check("xordn_c53", 32'(obs[53].xordn), 32'd1);
        check("tag_c53", 32'(obs[53].ena_tag), 32'd1);
        check("done_c54", 32'(obs[54].done), 32'd1);
        check("idle_c55", 32'(obs[55].busy), 32'd0);

        // Randomized start/valid/reset against the model, both instances
        for (int s = 0; s < 2; s++) begin
            sel   = s[0];
            nb    = s ? 1 : 4;
            stamp = 1000;
            model_reset();
            clear_tally();
            for (int c = 0; c < 1500; c++) begin
                if ($urandom_range(0, 199) == 0) do_reset();
                else step($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
            end
        end

        check("xordn_11_never", 32'(xd3_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
